// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit (package mdu_define).
package mdu_define;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

endpackage

// File: rtl/mdu_iter_prep.sv
// Operand preparation: magnitudes, result sign flags, and divide special cases
// (divide by zero, signed overflow) resolved before any iteration starts.
module mdu_operand_prep
  import mdu_define::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_a_abs,
  output logic [XLEN-1:0] o_b_abs,
  output logic            o_neg_q,
  output logic            o_neg_r,
  output logic            o_special,
  output logic [XLEN-1:0] o_special_res
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_op_t w_op;
  logic    w_signed_a;
  logic    w_signed_b;
  logic    w_neg_a;
  logic    w_neg_b;
  logic    w_div0;
  logic    w_ovf;

  assign w_op = mdu_op_t'(i_funct3);

  // MUL is treated as signed x signed: the low word is identical either way,
  // and it keeps the multiplier magnitude small for negative operands.
  always_comb begin
    w_signed_a = 1'b0;
    w_signed_b = 1'b0;
    case (w_op)
      MUL, MULH, DIV, REM: begin
        w_signed_a = 1'b1;
        w_signed_b = 1'b1;
      end
      MULHSU:  w_signed_a = 1'b1;
      default: ;
    endcase
  end

  assign w_neg_a = w_signed_a & i_a[XLEN-1];
  assign w_neg_b = w_signed_b & i_b[XLEN-1];
  assign o_a_abs = w_neg_a ? (~i_a + 1'b1) : i_a;
  assign o_b_abs = w_neg_b ? (~i_b + 1'b1) : i_b;
  assign o_neg_q = w_neg_a ^ w_neg_b;
  assign o_neg_r = w_neg_a;

  assign w_div0    = i_funct3[2] && (i_b == {XLEN{1'b0}});
  assign w_ovf     = ((w_op == DIV) || (w_op == REM)) &&
                     (i_a == MIN_NEG) && (i_b == {XLEN{1'b1}});
  assign o_special = w_div0 | w_ovf;

  always_comb begin
    o_special_res = {XLEN{1'b1}};
    if (w_div0) begin
      o_special_res = i_funct3[1] ? i_a : {XLEN{1'b1}};
    end else if (w_ovf) begin
      o_special_res = i_funct3[1] ? {XLEN{1'b0}} : MIN_NEG;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle. Optional macro MDU_EARLY_OUT_EN ends multiplies early.
module mdu_iter
  import mdu_define::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  instr_t           instr,
  input  logic [XLEN-1:0]  a_in,
  input  logic [XLEN-1:0]  b_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [XLEN-1:0]  c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rd_wr,
  output logic             busy,
  output mdu_state_t       dbg_state
);

  // Handshake: an op transfers on in_valid && in_ready (ready only in IDLE);
  // a result transfers on out_valid && out_ready; flush overrides both.

  mdu_state_t          r_state;
  mdu_state_t          w_next;
  logic [2:0]          r_funct3;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_b;
  logic [XLEN-1:0]     r_c_out;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_special;

  logic [XLEN-1:0]     w_a_abs;
  logic [XLEN-1:0]     w_b_abs;
  logic                w_neg_q;
  logic                w_neg_r;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;
  logic                w_accept;
  logic                w_is_mul;
  logic                w_iter_last;
  logic                w_skip_iter;
  logic [XLEN:0]       w_rem_sh;
  logic [XLEN:0]       w_rem_diff;
  logic                w_fits;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix_res;
  logic                w_unused_instr;

  mdu_operand_prep #(.XLEN(XLEN)) u_prep (
    .i_funct3      (instr.funct3),
    .i_a           (a_in),
    .i_b           (b_in),
    .o_a_abs       (w_a_abs),
    .o_b_abs       (w_b_abs),
    .o_neg_q       (w_neg_q),
    .o_neg_r       (w_neg_r),
    .o_special     (w_special),
    .o_special_res (w_special_res)
  );

  assign w_unused_instr = ^{instr.funct7, instr.rs2, instr.rs1, instr.rd, instr.opcode};

  assign w_accept = in_valid && (r_state == IDLE) && !flush;
  assign w_is_mul = !r_funct3[2];

`ifdef MDU_EARLY_OUT_EN
  assign w_iter_last = (r_cnt == CNT_W'(1)) || (w_is_mul && (r_b[XLEN-1:1] == '0));
  assign w_skip_iter = w_special || (!instr.funct3[2] && (w_b_abs == '0));
`else
  assign w_iter_last = (r_cnt == CNT_W'(1));
  assign w_skip_iter = w_special;
`endif

  // Restoring divide step: r_acc = {partial remainder, remaining dividend/quotient}.
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_rem_diff = w_rem_sh - {1'b0, r_b};
  assign w_fits     = (w_rem_sh >= {1'b0, r_b});

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = r_acc[XLEN-1:0];
    if (r_special) begin
      w_fix_res = r_acc[XLEN-1:0];
    end else if (w_is_mul) begin
      w_fix_res = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else begin
      w_fix_res = r_funct3[1] ? w_rem : w_quo;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_skip_iter ? FIX : ITER;
      ITER:    if (flush) w_next = IDLE; else if (w_iter_last) w_next = FIX;
      FIX:     w_next = flush ? IDLE : DONE;
      DONE:    if (flush || out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3  <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_b       <= '0;
      r_c_out   <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_funct3  <= instr.funct3;
          r_neg_q   <= w_neg_q;
          r_neg_r   <= w_neg_r;
          r_special <= w_special;
          r_cnt     <= CNT_W'(XLEN);
          r_b       <= w_b_abs;
          r_mcand   <= {{XLEN{1'b0}}, w_a_abs};
          // Special cases park their final value in the low accumulator word.
          if (w_special)             r_acc <= {{XLEN{1'b0}}, w_special_res};
          else if (!instr.funct3[2]) r_acc <= '0;
          else                       r_acc <= {{XLEN{1'b0}}, w_a_abs};
        end
        ITER: if (!flush) begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_is_mul) begin
            if (r_b[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
          end else if (w_fits) begin
            r_acc <= {w_rem_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
          end else begin
            r_acc <= {r_acc[2*XLEN-2:0], 1'b0};
          end
        end
        FIX: if (!flush) r_c_out <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign rd_wr     = out_valid;
  assign busy      = (r_state != IDLE);
  assign c_out     = r_c_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vector table, handshake/flush/reset sequences,
// and random ops checked against an arithmetic reference model.
module tb_mdu_iter;
  import mdu_define::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  instr_t      instr;
  logic [31:0] a_in, b_in, c_out;
  logic        in_valid, in_ready, flush, out_valid, out_ready, rd_wr, busy;
  mdu_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_MUL7 = 3;
  localparam int LAT_MUL0 = 1;
`else
  localparam int LAT_MUL7 = 33;
  localparam int LAT_MUL0 = 33;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_c;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];

  mdu_iter #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .c_out     (c_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_wr     (rd_wr),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ub = b;
    p  = '0;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] m;
    int          iters;
`endif
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
    end
`ifdef MDU_EARLY_OUT_EN
    m = ((op == 3'b000 || op == 3'b001) && b[31]) ? -b : b;
    iters = 0;
    for (int i = 0; i < 32; i++) if (m[i]) iters = i + 1;
    return iters + 1;
`else
    return 33;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    instr        = '0;
    instr.funct7 = FUNCT7_MULDIV;
    instr.funct3 = op;
    instr.opcode = 7'b0110011;
    a_in         = a;
    b_in         = b;
    in_valid     = 1'b1;
    guard        = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    start_op(op, a, b);
    wait_valid(lat);
    res = c_out;
    check("rd_wr", 32'(rd_wr), 32'd1);
    consume();
  endtask

  initial begin
    logic [31:0] res, exp_c, ra, rb;
    logic [2:0]  rop;
    int          lat, seen;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL7};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
    vecs[12] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'b000, 32'd12345,    32'd0,        32'd0,        LAT_MUL0};
    vecs[14] = '{3'b111, 32'd7,        32'd0,        32'd7,        1};

    // Clock/reset
    instr = '0; a_in = '0; b_in = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_c_out", c_out, 32'd0);
    check("rst_flags", {28'd0, out_valid, rd_wr, busy, in_ready}, 32'b0001);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_c", i), res, vecs[i].exp_c);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Result held while writeback stalls
    start_op(3'b101, 32'd100, 32'd7);
    wait_valid(lat);
    check("hold_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_c", i), c_out, 32'd14);
      check($sformatf("hold%0d_flags", i), {30'd0, out_valid, in_ready}, 32'b10);
    end
    consume();
    check("release_flags", {30'd0, out_valid, in_ready}, 32'b01);

    // Flush on the 10th iteration
    start_op(3'b011, 32'h12345678, 32'hFFFFFFFF);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_iter_flags", {30'd0, in_ready, busy}, 32'b10);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("flush_iter_no_valid", 32'(seen), 32'd0);

    // Flush while a result waits in DONE
    start_op(3'b111, 32'd100, 32'd7);
    wait_valid(lat);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done_flags", {30'd0, out_valid, in_ready}, 32'b01);

    // Flush with an offered op in IDLE: nothing accepted
    instr.funct3 = 3'b100; a_in = 32'd9; b_in = 32'd3;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_flags", {30'd0, in_ready, busy}, 32'b10);
    repeat (3) begin @(posedge clk); #1; end
    check("flush_idle_no_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of an iteration
    start_op(3'b100, 32'd1000, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {30'd0, busy, out_valid}, 32'b00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'b110, 32'hFFFFFFF9, 32'd2, res, lat);
    check("after_rst_c", res, 32'hFFFFFFFF);
    check("after_rst_lat", 32'(lat), 32'd33);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(0, 15);
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      exp_q.push_back(ref_result(rop, ra, rb));
      do_op(rop, ra, rb, res, lat);
      exp_c = exp_q.pop_front();
      check($sformatf("rnd%0d_op%0d_c", i, rop), res, exp_c);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_latency(rop, ra, rb)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
